// File: rtl/sweep_sequencer.sv
// Triangular sweep controller: drives an up/down counter lower -> upper -> lower,
// with a programmable dwell at each end and a repeat count, paced by tick.
module sweep_sequencer #(
  parameter int Size      = 8,
  parameter int DwellSize = 8,
  parameter int RepSize   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 tick,
  input  logic [Size-1:0]      lower,
  input  logic [Size-1:0]      upper,
  input  logic [DwellSize-1:0] dwell,
  input  logic [RepSize-1:0]   repeats,
  output logic [Size-1:0]      data_o,
  output logic                 direction_o,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RISE   = 3'd1,
    TOP    = 3'd2,
    FALL   = 3'd3,
    BOTTOM = 3'd4
  } state_t;

  state_t               state_r, state_s;
  logic [Size-1:0]      data_r, data_s;
  logic                 dir_r, dir_s;
  logic                 busy_r, busy_s;
  logic                 done_r, done_s;
  logic                 error_r, error_s;
  logic [Size-1:0]      lower_r, lower_s;
  logic [Size-1:0]      upper_r, upper_s;
  logic [DwellSize-1:0] dwell_r, dwell_s;
  logic [DwellSize-1:0] dwell_cnt_r, dwell_cnt_s;
  logic [RepSize-1:0]   rep_cnt_r, rep_cnt_s;

  // Next-state, counter and output logic for the sweep FSM.
  always_comb begin
    state_s     = state_r;
    data_s      = data_r;
    lower_s     = lower_r;
    upper_s     = upper_r;
    dwell_s     = dwell_r;
    dwell_cnt_s = dwell_cnt_r;
    rep_cnt_s   = rep_cnt_r;
    done_s      = 1'b0;
    error_s     = 1'b0;

    case (state_r)
      IDLE: begin
        if (start) begin
          if (lower <= upper) begin
            lower_s   = lower;
            upper_s   = upper;
            dwell_s   = dwell;
            rep_cnt_s = repeats;
            data_s    = lower;
            state_s   = RISE;
          end else begin
            error_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RISE: begin
        if (abort) begin
          state_s = IDLE;
        end else if (tick) begin
          if (data_r == upper_r) begin
            state_s     = TOP;
            dwell_cnt_s = dwell_r;
          end else begin
            data_s = data_r + Size'(1'b1);
          end
        end else begin
          state_s = RISE;
        end
      end
      TOP: begin
        if (abort) begin
          state_s = IDLE;
        end else if (tick) begin
          if (dwell_cnt_r == {DwellSize{1'b0}}) begin
            state_s = FALL;
          end else begin
            dwell_cnt_s = dwell_cnt_r - DwellSize'(1'b1);
          end
        end else begin
          state_s = TOP;
        end
      end
      FALL: begin
        if (abort) begin
          state_s = IDLE;
        end else if (tick) begin
          if (data_r == lower_r) begin
            state_s     = BOTTOM;
            dwell_cnt_s = dwell_r;
          end else begin
            data_s = data_r - Size'(1'b1);
          end
        end else begin
          state_s = FALL;
        end
      end
      BOTTOM: begin
        if (abort) begin
          state_s = IDLE;
        end else if (tick) begin
          if (dwell_cnt_r != {DwellSize{1'b0}}) begin
            dwell_cnt_s = dwell_cnt_r - DwellSize'(1'b1);
          end else if (rep_cnt_r == {RepSize{1'b0}}) begin
            state_s = IDLE;
            done_s  = 1'b1;
          end else begin
            rep_cnt_s = rep_cnt_r - RepSize'(1'b1);
            state_s   = RISE;
          end
        end else begin
          state_s = BOTTOM;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Direction and busy follow the state being entered, so they stay registered with it.
    busy_s = (state_s != IDLE);
    dir_s  = (state_s == FALL) || (state_s == BOTTOM);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      data_r      <= {Size{1'b0}};
      dir_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      lower_r     <= {Size{1'b0}};
      upper_r     <= {Size{1'b0}};
      dwell_r     <= {DwellSize{1'b0}};
      dwell_cnt_r <= {DwellSize{1'b0}};
      rep_cnt_r   <= {RepSize{1'b0}};
    end else begin
      state_r     <= state_s;
      data_r      <= data_s;
      dir_r       <= dir_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      error_r     <= error_s;
      lower_r     <= lower_s;
      upper_r     <= upper_s;
      dwell_r     <= dwell_s;
      dwell_cnt_r <= dwell_cnt_s;
      rep_cnt_r   <= rep_cnt_s;
    end
  end

  assign data_o      = data_r;
  assign direction_o = dir_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign error       = error_r;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Directed bench for sweep_sequencer: a table for the basic sweep plus
// hand-written sequences for rejection, repeats, sparse tick, abort and reset.
module tb_sweep_sequencer;

  logic       clock = 1'b0;
  logic       reset, start, abort, tick;
  logic [7:0] lower, upper, dwell;
  logic [3:0] repeats;
  logic [7:0] data_o;
  logic       direction_o, busy, done, error;

  int checks = 0;
  int failures = 0;

  sweep_sequencer #(.Size(8), .DwellSize(8), .RepSize(4)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .tick(tick),
    .lower(lower), .upper(upper), .dwell(dwell), .repeats(repeats),
    .data_o(data_o), .direction_o(direction_o), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       start;
    logic       tick;
    logic [7:0] data;
    logic       dir;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs [11];

  task automatic step();
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [7:0] d, input logic dr,
                           input logic b, input logic dn);
    check({name, ".data"}, {24'd0, data_o}, {24'd0, d});
    check({name, ".dir"},  {31'd0, direction_o}, {31'd0, dr});
    check({name, ".busy"}, {31'd0, busy}, {31'd0, b});
    check({name, ".done"}, {31'd0, done}, {31'd0, dn});
  endtask

  task automatic setup(input logic [7:0] lo, input logic [7:0] hi,
                       input logic [7:0] dw, input logic [3:0] rp);
    lower = lo; upper = hi; dwell = dw; repeats = rp;
  endtask

  initial begin
    logic [7:0] seq1 [10];
    logic [7:0] pat3 [6];
    logic       dir3 [6];

    // Basic sweep 2..4, dwell 1, no repeats: cycles 1..11 after the start edge.
    vecs[0]  = '{1'b1, 1'b1, 8'd2, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'd3, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'd4, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'd3, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 8'd2, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'd2, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'd2, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) seq1[i] = vecs[i].data;
    pat3 = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0};
    dir3 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    reset = 1'b1; start = 1'b0; abort = 1'b0; tick = 1'b0;
    setup(8'd0, 8'd0, 8'd0, 4'd0);
    step(); step();
    check_all("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    check("reset.error", {31'd0, error}, 32'd0);
    reset = 1'b0;

    // Test 1: table-driven sweep.
    setup(8'd2, 8'd4, 8'd1, 4'd0);
    for (int i = 0; i < 11; i++) begin
      start = vecs[i].start;
      tick  = vecs[i].tick;
      step();
      check_all($sformatf("t1[%0d]", i + 1), vecs[i].data, vecs[i].dir, vecs[i].busy, vecs[i].done);
    end
    step();
    check("t1.done_clear", {31'd0, done}, 32'd0);

    // Test 2: rejected start pulses error and leaves data_o alone.
    setup(8'd5, 8'd3, 8'd1, 4'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t2.error", {31'd0, error}, 32'd1);
    check_all("t2", 8'd2, 1'b0, 1'b0, 1'b0);
    step();
    check("t2.error_clear", {31'd0, error}, 32'd0);
    check("t2.busy", {31'd0, busy}, 32'd0);

    // Test 3: three sweeps 0..1, dwell 0.
    setup(8'd0, 8'd1, 8'd0, 4'd2);
    start = 1'b1; tick = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 18; c++) begin
      check_all($sformatf("t3[%0d]", c + 1), pat3[c % 6], dir3[c % 6], 1'b1, 1'b0);
      step();
    end
    check_all("t3.end", 8'd0, 1'b0, 1'b0, 1'b1);
    step();
    check("t3.done_once", {31'd0, done}, 32'd0);

    // Test 4: tick every third cycle stretches each value to three cycles.
    setup(8'd2, 8'd4, 8'd1, 4'd0);
    start = 1'b1; tick = 1'b0;
    step();
    start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      check($sformatf("t4.data[%0d]", k), {24'd0, data_o}, {24'd0, seq1[(k - 1) / 3]});
      check($sformatf("t4.done[%0d]", k), {31'd0, done}, 32'd0);
      tick = (k % 3 == 0);
      step();
    end
    tick = 1'b0;
    check_all("t4.end", 8'd2, 1'b0, 1'b0, 1'b1);

    // Test 5: abort in RISE at data 3, then lower==upper sweep is accepted.
    setup(8'd2, 8'd4, 8'd1, 4'd0);
    start = 1'b1; tick = 1'b1;
    step();
    start = 1'b0;
    step();
    check_all("t5.pre", 8'd3, 1'b0, 1'b1, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_all("t5.abort", 8'd3, 1'b0, 1'b0, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_all("t5.idle_abort", 8'd3, 1'b0, 1'b0, 1'b0);
    setup(8'd0, 8'd0, 8'd0, 4'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    check_all("t5.eq1", 8'd0, 1'b0, 1'b1, 1'b0);
    step();
    check_all("t5.eq2", 8'd0, 1'b0, 1'b1, 1'b0);
    step();
    check_all("t5.eq3", 8'd0, 1'b1, 1'b1, 1'b0);
    step();
    check_all("t5.eq4", 8'd0, 1'b1, 1'b1, 1'b0);
    step();
    check_all("t5.eq5", 8'd0, 1'b0, 1'b0, 1'b1);

    // Test 6: start while busy is ignored; reset in TOP clears everything.
    setup(8'd2, 8'd4, 8'd1, 4'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    check_all("t6.c1", 8'd2, 1'b0, 1'b1, 1'b0);
    setup(8'd0, 8'd7, 8'd5, 4'd3);
    start = 1'b1;
    step();
    start = 1'b0;
    check_all("t6.c2", 8'd3, 1'b0, 1'b1, 1'b0);
    step();
    check_all("t6.c3", 8'd4, 1'b0, 1'b1, 1'b0);
    step();
    check_all("t6.top", 8'd4, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_all("t6.reset", 8'd0, 1'b0, 1'b0, 1'b0);
    step();
    check_all("t6.after", 8'd0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
